seq_event_window_monitor: RTL

//  Downstream consumer of the 00/11 sequence detector output.

---
 rtl/seq_event_window_monitor.sv | 124 ++++++++++++
 1 files changed

// File: rtl/seq_event_window_monitor.sv
// Counts sequence-detector hits over fixed windows of WIN_LEN bit-times.
// Each window close produces one registered report (count + alarm) on a valid/ready port.
module seq_event_window_monitor #(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 8,
    parameter int THRESH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             det,
    input  logic             clr,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CNT_W-1:0] rpt_count,
    output logic             rpt_alarm,
    output logic             overrun
);

    // state     | meaning
    // RPT_EMPTY | no report pending, rpt_valid=0
    // RPT_FULL  | report pending and held stable, rpt_valid=1

    localparam int POS_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W:0]   THRESH_V = (CNT_W + 1)'(THRESH);

    typedef enum logic {
        RPT_EMPTY = 1'b0,
        RPT_FULL  = 1'b1
    } rpt_state_e;

    rpt_state_e       state_q, state_d;
    logic [POS_W-1:0] win_pos_q, win_pos_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             alarm_q, alarm_d;
    logic             overrun_q, overrun_d;

    logic [CNT_W-1:0] hit_inc;
    logic             close_alarm;
    logic             win_close;

    always_comb begin
        hit_inc     = (det && (hit_cnt_q != CNT_MAX)) ? hit_cnt_q + CNT_W'(1) : hit_cnt_q;
        close_alarm = ({1'b0, hit_inc} >= THRESH_V);
        // clr swallows any bit_en in the same cycle, so it can never close a window
        win_close   = bit_en && !clr && (win_pos_q == LAST_POS);

        win_pos_d = win_pos_q;
        hit_cnt_d = hit_cnt_q;
        if (clr) begin
            win_pos_d = '0;
            hit_cnt_d = '0;
        end else if (bit_en) begin
            if (win_close) begin
                win_pos_d = '0;
                hit_cnt_d = '0;
            end else begin
                win_pos_d = win_pos_q + POS_W'(1);
                hit_cnt_d = hit_inc;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        alarm_d   = alarm_q;
        overrun_d = overrun_q;

        case (state_q)
            RPT_EMPTY: begin
                if (win_close) begin
                    count_d = hit_inc;
                    alarm_d = close_alarm;
                    state_d = RPT_FULL;
                end
            end
            RPT_FULL: begin
                if (win_close) begin
                    if (rpt_ready) begin
                        count_d = hit_inc;
                        alarm_d = close_alarm;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else if (rpt_ready) begin
                    state_d = RPT_EMPTY;
                end
            end
            default: state_d = RPT_EMPTY;
        endcase

        if (clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RPT_EMPTY;
            win_pos_q <= '0;
            hit_cnt_q <= '0;
            count_q   <= '0;
            alarm_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            win_pos_q <= win_pos_d;
            hit_cnt_q <= hit_cnt_d;
            count_q   <= count_d;
            alarm_q   <= alarm_d;
            overrun_q <= overrun_d;
        end
    end

    assign rpt_valid = (state_q == RPT_FULL);
    assign rpt_count = count_q;
    assign rpt_alarm = alarm_q;
    assign overrun   = overrun_q;

endmodule
